// File: rtl/ex_issue_sequencer.sv
// Issue sequencer between decode and execute: one-entry hold register plus a
// pending-write scoreboard. Optional perf counters under EX_SEQ_PERF_EN.
module ex_issue_sequencer #(
    parameter int unsigned PAYLOAD_W = 160,
    parameter int unsigned REG_AW    = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_dec_valid,
    output logic                   o_dec_ready,
    input  logic [PAYLOAD_W-1:0]   i_dec_payload,
    input  logic [REG_AW-1:0]      i_rs1_addr,
    input  logic [REG_AW-1:0]      i_rs2_addr,
    input  logic                   i_uses_rs1,
    input  logic                   i_uses_rs2,
    input  logic [REG_AW-1:0]      i_rd_addr,
    input  logic                   i_rd_we,
    output logic                   o_ex_start,
    output logic [PAYLOAD_W-1:0]   o_ex_payload,
    input  logic                   i_ex_done,
    input  logic                   i_ex_pc_load,
    input  logic                   i_wb_valid,
    input  logic [REG_AW-1:0]      i_wb_rd_addr,
    output logic                   o_flush,
    output logic [(2**REG_AW)-1:0] o_scoreboard,
    output logic [1:0]             o_state
`ifdef EX_SEQ_PERF_EN
    ,
    output logic [31:0]            o_issue_count,
    output logic [31:0]            o_stall_count,
    output logic [31:0]            o_flush_count
`endif
);

    localparam int unsigned SB_W = 2**REG_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [REG_AW-1:0]   rs1_q, rs2_q, rd_q;
    logic                uses_rs1_q, uses_rs2_q, rd_we_q;
    logic                accept, hazard, start_n, flush_n, ready_n;
    logic [SB_W-1:0]     clr_mask, set_mask, sb_byp, sb_n;

    assign o_state = state;

    // Next state, scoreboard update and issue decision; writeback clears are
    // applied before the hazard check so a retiring write unblocks this cycle.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        start_n  = 1'b0;
        flush_n  = 1'b0;
        clr_mask = '0;
        set_mask = '0;
        if (i_wb_valid && (i_wb_rd_addr != '0)) begin
            clr_mask[i_wb_rd_addr] = 1'b1;
        end
        sb_byp = o_scoreboard & ~clr_mask;
        hazard = (uses_rs1_q && (rs1_q != '0) && sb_byp[rs1_q])
               | (uses_rs2_q && (rs2_q != '0) && sb_byp[rs2_q])
               | (rd_we_q    && (rd_q  != '0) && sb_byp[rd_q]);
        case (state)
            ST_IDLE: begin
                if (i_dec_valid && o_dec_ready) begin
                    accept  = 1'b1;
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!hazard) begin
                    start_n = 1'b1;
                    state_n = ST_WAIT;
                    if (rd_we_q && (rd_q != '0)) begin
                        set_mask[rd_q] = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (i_ex_done) begin
                    state_n = ST_IDLE;
                    flush_n = i_ex_pc_load;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        sb_n    = sb_byp | set_mask;
        ready_n = (state_n == ST_IDLE) && !flush_n;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            o_ex_start   <= 1'b0;
            o_flush      <= 1'b0;
            o_dec_ready  <= 1'b0;
            o_scoreboard <= '0;
            o_ex_payload <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            uses_rs1_q   <= 1'b0;
            uses_rs2_q   <= 1'b0;
            rd_we_q      <= 1'b0;
        end else begin
            state        <= state_n;
            o_ex_start   <= start_n;
            o_flush      <= flush_n;
            o_dec_ready  <= ready_n;
            o_scoreboard <= sb_n;
            if (accept) begin
                o_ex_payload <= i_dec_payload;
                rs1_q        <= i_rs1_addr;
                rs2_q        <= i_rs2_addr;
                rd_q         <= i_rd_addr;
                uses_rs1_q   <= i_uses_rs1;
                uses_rs2_q   <= i_uses_rs2;
                rd_we_q      <= i_rd_we;
            end
        end
    end

`ifdef EX_SEQ_PERF_EN
    logic stall;
    assign stall = (state == ST_HOLD) && hazard;

    // Saturating event counters
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_issue_count <= '0;
            o_stall_count <= '0;
            o_flush_count <= '0;
        end else begin
            if (start_n && (o_issue_count != 32'hFFFF_FFFF)) o_issue_count <= o_issue_count + 32'd1;
            if (stall   && (o_stall_count != 32'hFFFF_FFFF)) o_stall_count <= o_stall_count + 32'd1;
            if (flush_n && (o_flush_count != 32'hFFFF_FFFF)) o_flush_count <= o_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_issue_sequencer.sv
// Bench for ex_issue_sequencer: directed scenarios plus random traffic checked
// every cycle against a transaction-level model of the issue rules.
module tb_ex_issue_sequencer;

    localparam int unsigned PW = 160;
    localparam int unsigned AW = 5;

    logic           i_clk, i_reset;
    logic           i_dec_valid, o_dec_ready;
    logic [PW-1:0]  i_dec_payload, o_ex_payload;
    logic [AW-1:0]  i_rs1_addr, i_rs2_addr, i_rd_addr, i_wb_rd_addr;
    logic           i_uses_rs1, i_uses_rs2, i_rd_we;
    logic           o_ex_start, i_ex_done, i_ex_pc_load, i_wb_valid, o_flush;
    logic [31:0]    o_scoreboard;
    logic [1:0]     o_state;
`ifdef EX_SEQ_PERF_EN
    logic [31:0]    o_issue_count, o_stall_count, o_flush_count;
`endif

    ex_issue_sequencer #(.PAYLOAD_W(PW), .REG_AW(AW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready),
        .i_dec_payload(i_dec_payload),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_uses_rs1(i_uses_rs1), .i_uses_rs2(i_uses_rs2),
        .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we),
        .o_ex_start(o_ex_start), .o_ex_payload(o_ex_payload),
        .i_ex_done(i_ex_done), .i_ex_pc_load(i_ex_pc_load),
        .i_wb_valid(i_wb_valid), .i_wb_rd_addr(i_wb_rd_addr),
        .o_flush(o_flush), .o_scoreboard(o_scoreboard), .o_state(o_state)
`ifdef EX_SEQ_PERF_EN
        ,
        .o_issue_count(o_issue_count), .o_stall_count(o_stall_count),
        .o_flush_count(o_flush_count)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_err, n_chk;

    // Model: phase 0 = waiting for decode, 1 = instruction held, 2 = executing
    int          m_phase;
    bit [31:0]   m_pend;
    bit          m_start, m_flush, m_ready;
    bit [PW-1:0] m_payload;
    int          h_rs1, h_rs2, h_rd;
    bit          h_u1, h_u2, h_we;
    longint      m_issues, m_stalls, m_flushes;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pend = '0; m_start = 0; m_flush = 0; m_ready = 0;
        m_payload = '0; h_rs1 = 0; h_rs2 = 0; h_rd = 0; h_u1 = 0; h_u2 = 0; h_we = 0;
        m_issues = 0; m_stalls = 0; m_flushes = 0;
    endtask

    function automatic longint sat_inc(input longint v);
        return (v >= 64'h0000_0000_FFFF_FFFF) ? v : v + 1;
    endfunction

    // One clock of the issue rules, evaluated from the inputs present this cycle
    task automatic model_eval();
        bit [31:0] pend;
        bit        blocked;
        int        next_phase;
        if (i_reset) begin
            model_reset();
            return;
        end
        pend = m_pend;
        if (i_wb_valid && int'(i_wb_rd_addr) != 0) pend[int'(i_wb_rd_addr)] = 1'b0;
        next_phase = m_phase;
        m_start = 0;
        m_flush = 0;
        if (m_phase == 0) begin
            if (i_dec_valid && m_ready) begin
                m_payload = i_dec_payload;
                h_rs1 = int'(i_rs1_addr); h_rs2 = int'(i_rs2_addr); h_rd = int'(i_rd_addr);
                h_u1 = i_uses_rs1; h_u2 = i_uses_rs2; h_we = i_rd_we;
                next_phase = 1;
            end
        end else if (m_phase == 1) begin
            blocked = (h_u1 && h_rs1 != 0 && pend[h_rs1]) ||
                      (h_u2 && h_rs2 != 0 && pend[h_rs2]) ||
                      (h_we && h_rd  != 0 && pend[h_rd]);
            if (blocked) begin
                m_stalls = sat_inc(m_stalls);
            end else begin
                m_start = 1;
                m_issues = sat_inc(m_issues);
                if (h_we && h_rd != 0) pend[h_rd] = 1'b1;
                next_phase = 2;
            end
        end else if (i_ex_done) begin
            next_phase = 0;
            m_flush = i_ex_pc_load;
            if (m_flush) m_flushes = sat_inc(m_flushes);
        end
        m_pend  = pend;
        m_phase = next_phase;
        m_ready = (next_phase == 0) && !m_flush;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},   256'(o_state),      256'(m_phase));
        check({tag, ".start"},   256'(o_ex_start),   256'(m_start));
        check({tag, ".flush"},   256'(o_flush),      256'(m_flush));
        check({tag, ".ready"},   256'(o_dec_ready),  256'(m_ready));
        check({tag, ".sb"},      256'(o_scoreboard), 256'(m_pend));
        check({tag, ".payload"}, 256'(o_ex_payload), 256'(m_payload));
`ifdef EX_SEQ_PERF_EN
        check({tag, ".issues"},  256'(o_issue_count), 256'(m_issues));
        check({tag, ".stalls"},  256'(o_stall_count), 256'(m_stalls));
        check({tag, ".flushes"}, 256'(o_flush_count), 256'(m_flushes));
`endif
    endtask

    task automatic tick(input string tag);
        @(negedge i_clk);
        model_eval();
        @(posedge i_clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_dec(input bit v, input int rs1, input bit u1, input int rs2,
                           input bit u2, input int rd, input bit we);
        i_dec_valid   = v;
        i_rs1_addr    = AW'(rs1);
        i_uses_rs1    = u1;
        i_rs2_addr    = AW'(rs2);
        i_uses_rs2    = u2;
        i_rd_addr     = AW'(rd);
        i_rd_we       = we;
        i_dec_payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle_inputs();
        set_dec(0, 0, 0, 0, 0, 0, 0);
        i_ex_done = 0; i_ex_pc_load = 0; i_wb_valid = 0; i_wb_rd_addr = '0;
    endtask

    // Accept, issue and complete one instruction with no writeback traffic
    task automatic run_instr(input string tag, input int rs1, input bit u1,
                             input int rs2, input bit u2, input int rd, input bit we);
        set_dec(1, rs1, u1, rs2, u2, rd, we);
        tick({tag, ".acc"});
        check({tag, ".held"}, 256'(o_state), 256'(1));
        i_dec_valid = 0;
        tick({tag, ".iss"});
        check({tag, ".start_pulse"}, 256'(o_ex_start), 256'(1));
        i_ex_done = 1;
        tick({tag, ".done"});
        i_ex_done = 0;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        idle_inputs();
        i_reset = 1;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_all("rst");
        check("rst.ready_low", 256'(o_dec_ready), 256'(0));
        i_reset = 0;
        tick("rel");
        check("rel.ready_high", 256'(o_dec_ready), 256'(1));

        // x0 destination never enters the scoreboard
        run_instr("x0", 0, 1, 0, 0, 0, 1);
        check("x0.sb", 256'(o_scoreboard), 256'(0));
`ifdef EX_SEQ_PERF_EN
        check("x0.issues", 256'(o_issue_count), 256'(1));
        check("x0.stalls", 256'(o_stall_count), 256'(0));
`endif

        // back-to-back independent ADDI x1 / ADDI x2
        run_instr("b2b1", 0, 1, 0, 0, 1, 1);
        run_instr("b2b2", 0, 1, 0, 0, 2, 1);
        check("b2b.sb", 256'(o_scoreboard), 256'(32'h6));

        // RAW: ADD x6 = x5 + x5 waits for x5 writeback
        run_instr("raw_p", 0, 1, 0, 0, 5, 1);
        set_dec(1, 5, 1, 5, 1, 6, 1);
        tick("raw.acc");
        i_dec_valid = 0;
        repeat (2) begin
            tick("raw.hold");
            check("raw.no_start", 256'(o_ex_start), 256'(0));
            check("raw.in_hold", 256'(o_state), 256'(1));
        end
        i_wb_valid = 1; i_wb_rd_addr = 5'd5;
        tick("raw.wb");
        check("raw.start", 256'(o_ex_start), 256'(1));
        check("raw.sb", 256'(o_scoreboard), 256'(32'h46));
        i_wb_valid = 0; i_ex_done = 1;
        tick("raw.done");
        i_ex_done = 0;

        // bypass with set-wins on x7
        run_instr("byp_p", 0, 1, 0, 0, 7, 1);
        set_dec(1, 0, 1, 0, 0, 7, 1);
        tick("byp.acc");
        i_dec_valid = 0; i_wb_valid = 1; i_wb_rd_addr = 5'd7;
        tick("byp.iss");
        check("byp.start", 256'(o_ex_start), 256'(1));
        check("byp.sb", 256'(o_scoreboard), 256'(32'hC6));
        i_wb_valid = 0; i_ex_done = 1;
        tick("byp.done");
        i_ex_done = 0;

        // taken branch: flush pulse, decode offer during flush dropped
        set_dec(1, 3, 1, 4, 1, 0, 0);
        tick("br.acc");
        i_dec_valid = 0;
        tick("br.iss");
        i_ex_done = 1; i_ex_pc_load = 1;
        tick("br.done");
        check("br.flush", 256'(o_flush), 256'(1));
        check("br.sb", 256'(o_scoreboard), 256'(32'hC6));
        i_ex_done = 0; i_ex_pc_load = 0;
        set_dec(1, 0, 1, 0, 0, 9, 1);
        tick("br.drop");
        check("br.flush_end", 256'(o_flush), 256'(0));
        check("br.not_acc", 256'(o_state), 256'(0));
        tick("br.acc2");
        check("br.acc2_held", 256'(o_state), 256'(1));

        // async reset while an instruction is pending behind a hazard
        set_dec(0, 0, 0, 0, 0, 0, 0);
        tick("ar.iss");
        i_ex_done = 1;
        tick("ar.done");
        i_ex_done = 0;
        set_dec(1, 1, 1, 0, 0, 3, 1);
        tick("ar.acc");
        i_dec_valid = 0;
        tick("ar.hold");
        #2 i_reset = 1;
        #1;
        model_reset();
        check_all("ar");
        check("ar.sb", 256'(o_scoreboard), 256'(0));
        check("ar.state", 256'(o_state), 256'(0));
        tick("ar.held");
        check("ar.no_flush", 256'(o_flush), 256'(0));
        i_reset = 0;
        tick("ar.rel");
        check("ar.ready", 256'(o_dec_ready), 256'(1));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_dec(($urandom_range(0, 1) == 1), $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 7), ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
            i_ex_done    = ($urandom_range(0, 9) < 4);
            i_ex_pc_load = ($urandom_range(0, 3) == 0);
            i_wb_valid   = ($urandom_range(0, 9) < 3);
            i_wb_rd_addr = AW'($urandom_range(0, 7));
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
